fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the synchronous-read instruction ROM: `ADDR_WIDTH` word address in, `DATA_WIDTH` data out, 1-cycle read latency, no read enable.
- Holds the program counter and drives the ROM word address every cycle.
- Tracks the one-cycle-latency response and buffers returned instructions in a 2-entry queue.
- Presents instructions to decode with a valid/ready handshake. Supports one instruction per cycle sustained, stall via `ready_i`, and redirect (branch/jump) with flush.

---
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding a 1-cycle-latency ROM into a 2-entry queue
module fetch_unit #(
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    input  logic                  redirect_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]   pc_o
);

    logic [PC_WIDTH-1:0]   r_req_pc;
    logic [PC_WIDTH-1:0]   r_inflight_pc;
    logic                  r_inflight;
    logic [1:0]            r_count;
    logic                  r_head;
    logic [PC_WIDTH-1:0]   r_fifo_pc    [2];
    logic [DATA_WIDTH-1:0] r_fifo_instr [2];

    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_tail;
    logic [1:0]            w_occupancy;
    logic [PC_WIDTH-1:0]   w_redirect_pc;
    logic                  w_unused;

    assign valid_o       = (r_count != 2'd0);
    assign instr_o       = r_fifo_instr[r_head];
    assign pc_o          = r_fifo_pc[r_head];
    assign w_pop         = valid_o && ready_i;
    assign w_push        = r_inflight && !redirect_i;
    // Slots committed after this cycle's pop; a new request is only made if one stays free.
    assign w_occupancy   = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue       = !redirect_i && (w_occupancy < 2'd2);
    assign w_tail        = r_head ^ r_count[0];
    assign w_redirect_pc = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
    assign w_unused      = ^redirect_pc_i[1:0];

    always_comb begin
        imem_addr_o = r_req_pc[ADDR_WIDTH+1:2];
        if (rst_i) begin
            imem_addr_o = RESET_PC[ADDR_WIDTH+1:2];
        end else if (redirect_i) begin
            imem_addr_o = w_redirect_pc[ADDR_WIDTH+1:2];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req_pc      <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= 2'd0;
            r_head        <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
            end
        end else if (redirect_i) begin
            // The redirect target is requested this very cycle; the old response is dropped.
            r_count       <= 2'd0;
            r_inflight    <= 1'b1;
            r_inflight_pc <= w_redirect_pc;
            r_req_pc      <= w_redirect_pc + PC_WIDTH'(4);
        end else begin
            if (w_push) begin
                r_fifo_pc[w_tail]    <= r_inflight_pc;
                r_fifo_instr[w_tail] <= imem_data_i;
            end
            r_head     <= r_head ^ w_pop;
            r_count    <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_req_pc;
                r_req_pc      <= r_req_pc + PC_WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert ({1'b0, r_count} + {2'b00, r_inflight} <= 3'd2);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and random stimulus checked against an in-order PC stream model
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, redirect, ready, valid;
    logic [31:0] redirect_pc, rom, instr, pc;
    logic [7:0]  addr;

    logic        rst2, valid2;
    logic [31:0] rom2, instr2, pc2;
    logic [7:0]  addr2;

    fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .imem_addr_o(addr), .imem_data_i(rom),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .valid_o(valid), .ready_i(ready), .instr_o(instr), .pc_o(pc)
    );

    fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .PC_WIDTH(32), .RESET_PC(32'h3F8)) dut2 (
        .clk_i(clk), .rst_i(rst2), .imem_addr_o(addr2), .imem_data_i(rom2),
        .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .valid_o(valid2), .ready_i(1'b1), .instr_o(instr2), .pc_o(pc2)
    );

    always @(posedge clk) begin
        rom  <= 32'hA000_0000 | {24'h0, addr};
        rom2 <= 32'hA000_0000 | {24'h0, addr2};
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_pc  = 32'h0;
    int          age     = 0;
    int          age2    = 0;
    int          hs2     = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_instr, prev_pc;

    function automatic logic [31:0] rom_of(input logic [31:0] p);
        return 32'hA000_0000 | {24'h0, p[9:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model by what the edge will do.
    task automatic cycle();
        logic [31:0] p2;
        @(negedge clk);
        if (rst) begin
            chk("addr_in_reset", {24'h0, addr}, 32'h0);
        end else begin
            if (redirect) chk("addr_redirect", {24'h0, addr}, {24'h0, redirect_pc[9:2]});
            chk("valid", {31'h0, valid}, (age >= 2) ? 32'h1 : 32'h0);
            if (prev_stall) begin
                chk("hold_pc", pc, prev_pc);
                chk("hold_instr", instr, prev_instr);
            end
            if (valid) begin
                chk("head_pc", pc, exp_pc);
                chk("head_instr", instr, rom_of(exp_pc));
            end
        end
        if (!rst2) begin
            if (age2 < 4) chk("wrap_addr", {24'h0, addr2}, {24'h0, 8'(8'hFE + age2)});
            if (valid2 && hs2 < 3) begin
                p2 = 32'h3F8 + 32'(4 * hs2);
                chk("wrap_pc", pc2, p2);
                chk("wrap_instr", instr2, rom_of(p2));
            end
        end
        prev_stall = !rst && !redirect && valid && !ready;
        prev_instr = instr;
        prev_pc    = pc;
        if (rst) begin
            age    = 0;
            exp_pc = 32'h0;
        end else if (redirect) begin
            age    = 1;
            exp_pc = redirect_pc & ~32'h3;
        end else begin
            if (valid && ready) exp_pc += 32'h4;
            if (age < 1000) age++;
        end
        if (rst2) begin
            age2 = 0;
            hs2  = 0;
        end else begin
            if (valid2) hs2++;
            age2++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
        cycle();
        chk("reset_valid", {31'h0, valid}, 32'h0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_pc", pc, 32'h0);
        cycle();
        rst = 1'b0; rst2 = 1'b0;
        run(10);
        ready = 1'b0;
        run(5);
        ready = 1'b1;
        run(6);
        redirect = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect = 1'b0;
        run(5);
        ready = 1'b0;
        run(4);
        redirect = 1'b1; redirect_pc = 32'h43;
        cycle();
        redirect = 1'b0; ready = 1'b1;
        run(5);
        redirect = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect_pc = 32'h200;
        cycle();
        redirect = 1'b0;
        run(5);
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        cycle();
        rst = 1'b0; redirect = 1'b0;
        run(6);
        for (int i = 0; i < 500; i++) begin
            ready       = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            rst         = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0; redirect = 1'b0; ready = 1'b1;
        run(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
